// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem read,
// holds the word for decode, handles redirects and sticky halt.
module ifu_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  input  logic              rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_n;
  logic              r_discard;
  logic              w_discard_n;
  logic              r_halt_seen;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_err;

  logic              w_fire;
  logic              w_halt;
  logic              w_latch;
  logic [ADDR_W-1:0] w_redir_pc;
  state_t            w_rtn;

  assign req_valid  = (r_state == S_REQ) & ~rst;
  assign out_valid  = (r_state == S_HOLD) & ~rst;
  assign halted     = (r_state == S_HALT) & ~rst;
  assign req_addr   = r_pc;
  assign out_inst   = r_inst;
  assign out_pc     = r_out_pc;
  assign out_err    = r_err;

  assign w_fire     = req_valid & req_ready;
  assign w_halt     = halt | r_halt_seen;
  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  // Wherever we would return to REQ, a pending halt parks us instead.
  assign w_rtn      = w_halt ? S_HALT : S_REQ;

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_discard_n = r_discard;
    w_latch     = 1'b0;
    if (redirect_valid && r_state != S_HALT) begin
      w_pc_n = w_redir_pc;
    end
    unique case (r_state)
      S_REQ: begin
        if (w_fire) begin
          w_state_n   = S_WAIT;
          w_discard_n = redirect_valid;
        end else if (w_halt) begin
          w_state_n = S_HALT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (r_discard || redirect_valid) begin
            w_discard_n = 1'b0;
            w_state_n   = w_rtn;
          end else begin
            w_latch   = 1'b1;
            w_state_n = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_discard_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_state_n = w_rtn;
        end else if (out_ready) begin
          w_pc_n    = r_pc + ADDR_W'(4);
          w_state_n = w_rtn;
        end
      end
      S_HALT: begin
        w_state_n = S_HALT;
      end
      default: begin
        w_state_n = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_halt_seen <= 1'b0;
      r_inst      <= '0;
      r_out_pc    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_discard   <= w_discard_n;
      r_halt_seen <= w_halt;
      if (w_latch) begin
        r_inst   <= rsp_data;
        r_out_pc <= r_pc;
        r_err    <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small behavioural
// instruction memory (inst = {addr[15:0], 16'h0013}).
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  logic [31:0] err_addr = 32'h8000_0008;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Memory: samples the handshake just before the edge, answers
  // lat cycles later for exactly one cycle.
  initial begin : mem
    logic [31:0] a;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (req_valid && req_ready) begin
        a = req_addr;
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = {a[15:0], 16'h0013};
        rsp_err   = (a == err_addr);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = req_valid;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_addr"}, req_addr, addr);
  endtask

  task automatic wait_out(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic err);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = out_valid;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  initial begin
    rst            = 1'b1;
    req_ready      = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_req0_valid", 32'(req_valid), 32'd1);
    chk("t1_req0_addr", req_addr, 32'h8000_0000);
    step();
    chk("t1_wait_req", 32'(req_valid), 32'd0);
    chk("t1_wait_out", 32'(out_valid), 32'd0);
    step();
    chk("t1_out0_valid", 32'(out_valid), 32'd1);
    chk("t1_out0_pc", out_pc, 32'h8000_0000);
    chk("t1_out0_inst", out_inst, 32'h0000_0013);
    chk("t1_out0_err", 32'(out_err), 32'd0);
    step();
    chk("t1_req1_addr", req_addr, 32'h8000_0004);
    chk("t1_req1_valid", 32'(req_valid), 32'd1);
    step();
    step();
    chk("t1_out1_valid", 32'(out_valid), 32'd1);
    chk("t1_out1_pc", out_pc, 32'h8000_0004);
    chk("t1_out1_inst", out_inst, 32'h0004_0013);
    step();
    chk("t1_req2_addr", req_addr, 32'h8000_0008);
    out_ready = 1'b0;
    step();
    step();
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t6_err_pc", out_pc, 32'h8000_0008);
    chk("t6_err", 32'(out_err), 32'd1);
    chk("t2_inst", out_inst, 32'h0008_0013);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_pc", out_pc, 32'h8000_0008);
      chk("t2_hold_inst", out_inst, 32'h0008_0013);
      chk("t2_hold_req", 32'(req_valid), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t2_next_addr", req_addr, 32'h8000_000C);
    chk("t2_next_valid", 32'(req_valid), 32'd1);
    lat = 2;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    lat            = 0;
    step();
    redirect_valid = 1'b0;
    chk("t3_drop_a", 32'(out_valid), 32'd0);
    step();
    chk("t3_drop_b", 32'(out_valid), 32'd0);
    chk("t3_wait_req", 32'(req_valid), 32'd0);
    step();
    chk("t3_drop_c", 32'(out_valid), 32'd0);
    chk("t3_req_valid", 32'(req_valid), 32'd1);
    chk("t3_req_addr", req_addr, 32'h8000_1000);
    wait_out("t3_out", 32'h8000_1000, 32'h1000_0013, 1'b0);
    wait_req("t4_req", 32'h8000_1004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0010;
    step();
    redirect_valid = 1'b0;
    chk("t4_hs_drop", 32'(out_valid), 32'd0);
    chk("t4_hs_addr", req_addr, 32'h8000_0010);
    wait_out("t4_out", 32'h8000_0010, 32'h0010_0013, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    step();
    redirect_valid = 1'b0;
    chk("t4_redir_valid", 32'(req_valid), 32'd1);
    chk("t4_redir_addr", req_addr, 32'h8000_2000);
    chk("t4_redir_out", 32'(out_valid), 32'd0);
    wait_out("t6_pre", 32'h8000_2000, 32'h2000_0013, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("t6_align", req_addr, 32'hFFFF_FFFC);
    wait_out("t6_top", 32'hFFFF_FFFC, 32'hFFFC_0013, 1'b0);
    wait_req("t6_wrap", 32'h0000_0000);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t5_hold_valid", 32'(out_valid), 32'd1);
    chk("t5_hold_pc", out_pc, 32'h0000_0000);
    chk("t5_hold_halted", 32'(halted), 32'd0);
    step();
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_out", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_stay_halted", 32'(halted), 32'd1);
      chk("t5_stay_noreq", 32'(req_valid), 32'd0);
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_req", 32'(req_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_rst_addr", req_addr, 32'h8000_0000);
    chk("t5_rst_valid", 32'(req_valid), 32'd1);
    wait_out("t5_refetch", 32'h8000_0000, 32'h0000_0013, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
